// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer and the light sequencer that consumes it.
package interval_timer_pkg;

    localparam int TIME_W = 4;

    typedef logic [TIME_W-1:0] time_t;

    // Interval select / parameter select coding
    typedef enum logic [1:0] {
        INT_BASE = 2'b00,
        INT_EXT  = 2'b01,
        INT_YEL  = 2'b10,
        INT_RSVD = 2'b11
    } interval_e;

    // Default interval lengths in seconds
    localparam time_t T_BASE_DEFAULT = 4'd6;
    localparam time_t T_EXT_DEFAULT  = 4'd3;
    localparam time_t T_YEL_DEFAULT  = 4'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The reserved code behaves as the base interval.
    function automatic interval_e decode_interval(input logic [1:0] code);
        case (code)
            2'b01:   decode_interval = INT_EXT;
            2'b10:   decode_interval = INT_YEL;
            default: decode_interval = INT_BASE;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler: counts 0..CLK_PER_SEC-1 while enabled and flags the terminal count.
module sec_tick_gen #(
    parameter int CLK_PER_SEC = 100
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable seconds-based interval timer with restartable count and
// synchronous reprogramming of the three interval lengths.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int         CLK_PER_SEC = 100,
    parameter logic [3:0] T_BASE_DEF  = T_BASE_DEFAULT,
    parameter logic [3:0] T_EXT_DEF   = T_EXT_DEFAULT,
    parameter logic [3:0] T_YEL_DEF   = T_YEL_DEFAULT
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start_Timer,
    input  logic [1:0] Interval,
    input  logic       Sync_Reprogram,
    input  logic [1:0] Time_Param_Selector,
    input  logic [3:0] Time_Value,
    output logic       Expired,
    output logic       Busy,
    output logic [3:0] Remaining
);

    state_e state_q, state_d;
    time_t  remaining_q, remaining_d;
    logic   expired_q, expired_d;
    logic   start_q;
    time_t  base_q, base_d;
    time_t  ext_q, ext_d;
    time_t  yel_q, yel_d;

    logic   start_edge;
    logic   prescale_clear;
    logic   tick;
    time_t  sel_time;

    assign start_edge = Start_Timer && !start_q;

    sec_tick_gen #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_sec_tick_gen (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (prescale_clear),
        .enable (state_q == ST_RUN),
        .tick   (tick)
    );

    // Interval length chosen by the current Interval select.
    always_comb begin
        case (decode_interval(Interval))
            INT_EXT: sel_time = ext_q;
            INT_YEL: sel_time = yel_q;
            default: sel_time = base_q;
        endcase
    end

    // Next state: reprogram aborts and wins over start; start wins over expiry.
    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        expired_d      = 1'b0;
        prescale_clear = 1'b0;
        base_d         = base_q;
        ext_d          = ext_q;
        yel_d          = yel_q;

        if (Sync_Reprogram) begin
            if (Time_Value != '0) begin
                case (decode_interval(Time_Param_Selector))
                    INT_EXT: ext_d  = Time_Value;
                    INT_YEL: yel_d  = Time_Value;
                    default: base_d = Time_Value;
                endcase
            end
            state_d        = ST_IDLE;
            remaining_d    = '0;
            prescale_clear = 1'b1;
        end else if (start_edge) begin
            state_d        = ST_RUN;
            remaining_d    = sel_time;
            prescale_clear = 1'b1;
        end else if ((state_q == ST_RUN) && tick) begin
            if (remaining_q <= time_t'(1)) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end else begin
                remaining_d = remaining_q - time_t'(1);
            end
        end
    end

    // State, count, pulse, start-edge and parameter registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            start_q     <= 1'b0;
            base_q      <= T_BASE_DEF;
            ext_q       <= T_EXT_DEF;
            yel_q       <= T_YEL_DEF;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            start_q     <= Start_Timer;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
        end
    end

    assign Expired   = expired_q;
    assign Busy      = (state_q == ST_RUN);
    assign Remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Scenario bench for interval_timer with CLK_PER_SEC = 4.
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start_Timer = 1'b0;
    logic [1:0] Interval = 2'b00;
    logic       Sync_Reprogram = 1'b0;
    logic [1:0] Time_Param_Selector = 2'b00;
    logic [3:0] Time_Value = 4'd0;
    logic       Expired;
    logic       Busy;
    logic [3:0] Remaining;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q[$];
    int obs_q[$];

    interval_timer #(.CLK_PER_SEC(4)) dut (
        .clk                (clk),
        .Reset              (Reset),
        .Start_Timer        (Start_Timer),
        .Interval           (Interval),
        .Sync_Reprogram     (Sync_Reprogram),
        .Time_Param_Selector(Time_Param_Selector),
        .Time_Value         (Time_Value),
        .Expired            (Expired),
        .Busy               (Busy),
        .Remaining          (Remaining)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge index after which Expired was observed high
    always @(negedge clk) if (Expired) obs_q.push_back(cyc);

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        idle(2);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", Busy); end
        tests++; if (Remaining !== 4'd0) begin fails++; $display("FAIL reset_remaining: got %0d, expected 0", Remaining); end
        tests++; if (Expired !== 1'b0) begin fails++; $display("FAIL reset_expired: got %b, expected 0", Expired); end
        Reset = 1'b0;
        idle(2);
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_base;
        int e, o;
        Interval = 2'b00; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 24);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL base_busy: got %b, expected 1", Busy); end
        tests++; if (Remaining !== 4'd6) begin fails++; $display("FAIL base_load: got %0d, expected 6", Remaining); end
        idle(4);
        tests++; if (Remaining !== 4'd5) begin fails++; $display("FAIL base_decrement: got %0d, expected 5", Remaining); end
        idle(26);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL base_busy_after: got %b, expected 0", Busy); end
        tests++; if (Remaining !== 4'd0) begin fails++; $display("FAIL base_idle_remaining: got %0d, expected 0", Remaining); end
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL base_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL base_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reprogram;
        int e, o;
        // yel = 5, then a yellow interval of 20 cycles
        Sync_Reprogram = 1'b1; Time_Param_Selector = 2'b10; Time_Value = 4'd5;
        @(negedge clk);
        Sync_Reprogram = 1'b0; Time_Value = 4'd0;
        Interval = 2'b10; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 20);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd5) begin fails++; $display("FAIL reprog_yel_load: got %0d, expected 5", Remaining); end
        idle(24);
        // start base, then abort it with a zero-valued write to ext
        Interval = 2'b00; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        idle(5);
        Sync_Reprogram = 1'b1; Time_Param_Selector = 2'b01; Time_Value = 4'd0;
        @(negedge clk);
        Sync_Reprogram = 1'b0;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reprog_abort_busy: got %b, expected 0", Busy); end
        tests++; if (Remaining !== 4'd0) begin fails++; $display("FAIL reprog_abort_remaining: got %0d, expected 0", Remaining); end
        idle(25);
        // ext must still be 3
        Interval = 2'b01; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 12);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd3) begin fails++; $display("FAIL reprog_ext_kept: got %0d, expected 3", Remaining); end
        idle(16);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL reprog_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL reprog_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_hold;
        int e, o;
        Interval = 2'b00; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 24);
        idle(30);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL hold_no_restart: got busy %b, expected 0", Busy); end
        Start_Timer = 1'b0;
        idle(4);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL hold_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL hold_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_restart;
        int e, o;
        Interval = 2'b00; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        idle(9);
        Interval = 2'b01; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 12);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd3) begin fails++; $display("FAIL restart_load: got %0d, expected 3", Remaining); end
        idle(24);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL restart_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL restart_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        int e, o;
        Sync_Reprogram = 1'b1; Time_Param_Selector = 2'b00; Time_Value = 4'd9;
        @(negedge clk);
        Sync_Reprogram = 1'b0; Time_Value = 4'd0;
        Interval = 2'b00; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd9) begin fails++; $display("FAIL mid_base9_load: got %0d, expected 9", Remaining); end
        idle(9);
        Reset = 1'b1;
        #1;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b, expected 0", Busy); end
        tests++; if (Remaining !== 4'd0) begin fails++; $display("FAIL mid_reset_remaining: got %0d, expected 0", Remaining); end
        @(negedge clk);
        Reset = 1'b0;
        idle(40);
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mid_reset_no_expire: got %0d pulses, expected 0", obs_q.size()); end
        obs_q.delete();
        // defaults restored: 6 / 3 / 2, each via a fresh start edge
        Interval = 2'b00; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd6) begin fails++; $display("FAIL mid_default_base: got %0d, expected 6", Remaining); end
        @(negedge clk);
        Interval = 2'b01; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd3) begin fails++; $display("FAIL mid_default_ext: got %0d, expected 3", Remaining); end
        @(negedge clk);
        Interval = 2'b10; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 8);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd2) begin fails++; $display("FAIL mid_default_yel: got %0d, expected 2", Remaining); end
        idle(12);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL mid_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL mid_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int e, o, k;
        // yellow (2 s = 8 cycles), restart exactly on its expiring tick
        Interval = 2'b10; Start_Timer = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        Start_Timer = 1'b0;
        while (cyc < k + 7) @(negedge clk);
        Interval = 2'b01; Start_Timer = 1'b1;
        exp_q.push_back(k + 8 + 12);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b, expected 1", Busy); end
        tests++; if (Remaining !== 4'd3) begin fails++; $display("FAIL b2b_reload: got %0d, expected 3", Remaining); end
        idle(16);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL b2b_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_collision;
        int e, o;
        Interval = 2'b00; Start_Timer = 1'b1;
        Sync_Reprogram = 1'b1; Time_Param_Selector = 2'b01; Time_Value = 4'd7;
        @(negedge clk);
        Sync_Reprogram = 1'b0; Time_Value = 4'd0;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL collide_idle: got busy %b, expected 0", Busy); end
        idle(3);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL collide_held_start: got busy %b, expected 0", Busy); end
        Start_Timer = 1'b0;
        @(negedge clk);
        Interval = 2'b01; Start_Timer = 1'b1;
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd7) begin fails++; $display("FAIL collide_ext_written: got %0d, expected 7", Remaining); end
        @(negedge clk);
        Interval = 2'b11; Start_Timer = 1'b1;
        exp_q.push_back(cyc + 1 + 24);
        @(negedge clk);
        Start_Timer = 1'b0;
        tests++; if (Remaining !== 4'd6) begin fails++; $display("FAIL reserved_load: got %0d, expected 6", Remaining); end
        idle(28);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL collide_pulses: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if (o != e) begin fails++; $display("FAIL reserved_expire_cycle: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_base();
        test_reprogram();
        test_hold();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
